// File: rtl/alu_pkg.sv
// Shared encodings, operation enum and instruction decoder for alu_exec_unit.
package alu_pkg;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_ILLEGAL
    } alu_op_e;

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_e;

    // Base integer ops selected by funct3 alone (funct7 = 0 encodings).
    function automatic alu_op_e base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    // Multiply/divide ops selected by funct3.
    function automatic alu_op_e md_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return OP_MUL;
            3'b001:  return OP_MULH;
            3'b010:  return OP_MULHSU;
            3'b011:  return OP_MULHU;
            3'b100:  return OP_DIV;
            3'b101:  return OP_DIVU;
            3'b110:  return OP_REM;
            default: return OP_REMU;
        endcase
    endfunction

    // Full aluop/funct3/funct7 decode; anything unrecognised maps to OP_ILLEGAL.
    function automatic alu_op_e decode_op(input logic [1:0] aluop, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic en_m);
        case (aluop)
            ALUOP_MEM: return OP_ADD;
            ALUOP_BR:  return OP_SUB;
            ALUOP_R: begin
                if (f7 == F7_BASE) return base_op(f3);
                if (f7 == F7_ALT) begin
                    if (f3 == 3'b000) return OP_SUB;
                    if (f3 == 3'b101) return OP_SRA;
                    return OP_ILLEGAL;
                end
                if (f7 == F7_MULDIV && en_m) return md_op(f3);
                return OP_ILLEGAL;
            end
            default: begin
                // Immediate forms: funct7 only matters for the shift encodings.
                if (f3 == 3'b001) return (f7 == F7_BASE) ? OP_SLL : OP_ILLEGAL;
                if (f3 == 3'b101) begin
                    if (f7 == F7_BASE) return OP_SRL;
                    if (f7 == F7_ALT)  return OP_SRA;
                    return OP_ILLEGAL;
                end
                return base_op(f3);
            end
        endcase
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply (shift-add) / divide (restoring) engine, one bit per cycle.
// Works on magnitudes; signs are applied to the final value. o_done/o_result
// are valid combinationally during the last iteration cycle.
module alu_muldiv_iter import alu_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  alu_op_e         i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);
    localparam int CW = $clog2(XLEN);

    logic              r_busy;
    logic [CW-1:0]     r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_b;
    alu_op_e           r_op;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_is_div;

    logic              w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
    logic [XLEN-1:0]   w_mag_a, w_mag_b;
    logic [XLEN:0]     w_mul_sum, w_rem_sh, w_diff;
    logic [2*XLEN-1:0] w_acc_next, w_prod;
    logic [XLEN-1:0]   w_quo, w_rem;

    // Operand signedness and magnitudes for the op being launched.
    always_comb begin
        w_a_sgn = (i_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        w_b_sgn = (i_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
        w_a_neg = w_a_sgn & i_a[XLEN-1];
        w_b_neg = w_b_sgn & i_b[XLEN-1];
        w_mag_a = w_a_neg ? -i_a : i_a;
        w_mag_b = w_b_neg ? -i_b : i_b;
    end

    // One iteration step: acc holds {partial product, multiplier} or {remainder, quotient}.
    always_comb begin
        w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
        w_rem_sh  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_diff    = w_rem_sh - {1'b0, r_b};
        if (!r_is_div)
            w_acc_next = {w_mul_sum, r_acc[XLEN-1:1]};
        else if (w_diff[XLEN])
            w_acc_next = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        else
            w_acc_next = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        w_prod = r_neg_q ? -w_acc_next : w_acc_next;
        w_quo  = r_neg_q ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
        w_rem  = r_neg_r ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];
        case (r_op)
            OP_MUL:                       o_result = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: o_result = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              o_result = w_quo;
            default:                      o_result = w_rem;
        endcase
    end

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == '0);

    // Iteration control: XLEN steps, counter runs XLEN-1 down to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= CW'(XLEN - 1);
        end else if (r_busy) begin
            if (r_cnt == '0) r_busy <= 1'b0;
            else             r_cnt  <= r_cnt - 1'b1;
        end
    end

    // Datapath registers: load magnitudes at start, step while busy.
    always_ff @(posedge clk) begin
        if (i_start) begin
            r_acc    <= {{XLEN{1'b0}}, w_mag_a};
            r_b      <= w_mag_b;
            r_op     <= i_op;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_is_div <= (i_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
        end else if (r_busy) begin
            r_acc <= w_acc_next;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: RV32I/M decode, single-cycle datapath, iterative mul/div,
// valid/ready handshake on both sides with registered result and branch flags.
module alu_exec_unit import alu_pkg::*; #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      aluop,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            lt,
    output logic            ltu,
    output logic            illegal
);
    localparam int SW = $clog2(XLEN);
    localparam logic [XLEN-1:0] L_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e          r_state;
    logic            r_out_valid;
    logic [XLEN-1:0] r_result;
    logic            r_zero, r_lt, r_ltu, r_illegal;

    alu_op_e         w_op;
    logic [SW-1:0]   w_shamt;
    logic            w_lt, w_ltu, w_is_md, w_special, w_accept;
    logic [XLEN-1:0] w_alu;
    logic            w_md_busy, w_md_done;
    logic [XLEN-1:0] w_md_result;

    assign w_op     = decode_op(aluop, funct3, funct7, ENABLE_M);
    assign w_shamt  = opb[SW-1:0];
    assign w_lt     = $signed(opa) < $signed(opb);
    assign w_ltu    = opa < opb;
    assign w_is_md  = (w_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                                    OP_DIV, OP_DIVU, OP_REM, OP_REMU});
    assign in_ready = (r_state == ST_IDLE) && !rst && !w_md_busy;
    assign w_accept = in_valid && in_ready;

    // Single-cycle results, including divide-by-zero and signed-overflow shortcuts.
    always_comb begin
        w_alu     = '0;
        w_special = 1'b0;
        case (w_op)
            OP_ADD:  w_alu = opa + opb;
            OP_SUB:  w_alu = opa - opb;
            OP_SLL:  w_alu = opa << w_shamt;
            OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, w_lt};
            OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, w_ltu};
            OP_XOR:  w_alu = opa ^ opb;
            OP_SRL:  w_alu = opa >> w_shamt;
            OP_SRA:  w_alu = $signed(opa) >>> w_shamt;
            OP_OR:   w_alu = opa | opb;
            OP_AND:  w_alu = opa & opb;
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                if (opb == '0) begin
                    w_special = 1'b1;
                    w_alu     = (w_op inside {OP_DIV, OP_DIVU}) ? '1 : opa;
                end else if ((w_op inside {OP_DIV, OP_REM}) && opa == L_MIN && opb == '1) begin
                    w_special = 1'b1;
                    w_alu     = (w_op == OP_DIV) ? L_MIN : '0;
                end
            end
            default: w_alu = '0;
        endcase
    end

    alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_accept && w_is_md && !w_special),
        .i_op     (w_op),
        .i_a      (opa),
        .i_b      (opb),
        .o_busy   (w_md_busy),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );

    // Control FSM with registered result and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_lt        <= 1'b0;
            r_ltu       <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_lt      <= w_lt;
                        r_ltu     <= w_ltu;
                        r_illegal <= (w_op == OP_ILLEGAL);
                        if (w_is_md && !w_special) begin
                            r_state <= ST_CALC;
                        end else begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_alu;
                            r_zero      <= (w_alu == '0);
                        end
                    end
                end
                ST_CALC: begin
                    if (w_md_done) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_md_result;
                        r_zero      <= (w_md_result == '0);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign lt        = r_lt;
    assign ltu       = r_ltu;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed, table-driven bench for alu_exec_unit (XLEN=32, ENABLE_M=1).
module tb_alu_exec_unit;

    localparam logic [1:0] MEM = 2'b00, BR = 2'b01, RR = 2'b10, II = 2'b11;
    localparam logic [6:0] FB = 7'h00, FA = 7'h20, FM = 7'h01;

    typedef struct {
        logic [1:0]  aluop;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        lt;
        logic        ltu;
        logic        ill;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [1:0]  aluop;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] opa, opb;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic        zero, lt, ltu, illegal;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .funct3(funct3), .funct7(funct7), .opa(opa), .opb(opb),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .lt(lt), .ltu(ltu), .illegal(illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Offer an op at a negedge once in_ready is seen; accept happens at the next posedge.
    // Operands are scrambled right after accept so any late sampling shows up.
    task automatic start_op(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("in_ready_wait", 32'(in_ready), 32'd1);
        aluop = op; funct3 = f3; funct7 = f7; opa = a; opb = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opa = $urandom;
        opb = $urandom;
    endtask

    // Cycles from accept edge to out_valid; left sampling at a negedge with out_valid high.
    task automatic wait_result(output int lat);
        bit found;
        found = 1'b0;
        lat = 1;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (out_valid) found = 1'b1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        if (!found) lat = 999;
    endtask

    // Called at a negedge with out_valid high.
    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_drain_ovalid"}, 32'(out_valid), 32'd0);
        chk({tag, "_drain_iready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int ov_seen;
        string nm;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        aluop = '0; funct3 = '0; funct7 = '0; opa = '0; opb = '0;

        //           aluop f3  f7    a            b            res          z  lt ltu ill lat
        vecs.push_back('{RR, 3'd0, FB, 32'd5,        32'd7,        32'd12,       1'b0,1'b1,1'b1,1'b0,1});
        vecs.push_back('{BR, 3'd0, FB, 32'h1234,     32'h1234,     32'd0,        1'b1,1'b0,1'b0,1'b0,1});
        vecs.push_back('{BR, 3'd0, FB, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 1'b0,1'b1,1'b0,1'b0,1});
        vecs.push_back('{II, 3'd5, FA, 32'h80000000, 32'd4,        32'hF8000000, 1'b0,1'b1,1'b0,1'b0,1});
        vecs.push_back('{II, 3'd5, 7'h03, 32'h80000000, 32'd4,     32'd0,        1'b1,1'b1,1'b0,1'b1,1});
        vecs.push_back('{RR, 3'd0, FA, 32'd10,       32'd3,        32'd7,        1'b0,1'b0,1'b0,1'b0,1});
        vecs.push_back('{RR, 3'd2, FB, 32'hFFFFFFFB, 32'd3,        32'd1,        1'b0,1'b1,1'b0,1'b0,1});
        vecs.push_back('{RR, 3'd3, FB, 32'hFFFFFFFB, 32'd3,        32'd0,        1'b1,1'b1,1'b0,1'b0,1});
        vecs.push_back('{RR, 3'd1, FA, 32'd1,        32'd2,        32'd0,        1'b1,1'b1,1'b1,1'b1,1});
        vecs.push_back('{II, 3'd1, FB, 32'd1,        32'd31,       32'h80000000, 1'b0,1'b1,1'b1,1'b0,1});
        vecs.push_back('{II, 3'd1, FA, 32'd1,        32'd31,       32'd0,        1'b1,1'b1,1'b1,1'b1,1});
        vecs.push_back('{II, 3'd0, FA, 32'd10,       32'hFFFFFFFF, 32'd9,        1'b0,1'b0,1'b1,1'b0,1});
        vecs.push_back('{MEM,3'd7, 7'h7F, 32'h1000,  32'h20,       32'h1020,     1'b0,1'b0,1'b0,1'b0,1});
        vecs.push_back('{RR, 3'd4, FB, 32'hF0F0,     32'h0FF0,     32'hFF00,     1'b0,1'b0,1'b0,1'b0,1});
        vecs.push_back('{RR, 3'd5, FB, 32'h80000000, 32'd4,        32'h08000000, 1'b0,1'b1,1'b0,1'b0,1});
        vecs.push_back('{RR, 3'd6, FB, 32'h0F,       32'hF0,       32'hFF,       1'b0,1'b1,1'b1,1'b0,1});
        vecs.push_back('{RR, 3'd7, FB, 32'h0F,       32'hF0,       32'd0,        1'b1,1'b1,1'b1,1'b0,1});
        vecs.push_back('{RR, 3'd1, FM, 32'h80000000, 32'd2,        32'hFFFFFFFF, 1'b0,1'b1,1'b0,1'b0,33});
        vecs.push_back('{RR, 3'd4, FM, 32'd9,        32'd0,        32'hFFFFFFFF, 1'b0,1'b0,1'b0,1'b0,1});
        vecs.push_back('{RR, 3'd6, FM, 32'd9,        32'd0,        32'd9,        1'b0,1'b0,1'b0,1'b0,1});
        vecs.push_back('{RR, 3'd5, FM, 32'd9,        32'd0,        32'hFFFFFFFF, 1'b0,1'b0,1'b0,1'b0,1});
        vecs.push_back('{RR, 3'd7, FM, 32'd9,        32'd0,        32'd9,        1'b0,1'b0,1'b0,1'b0,1});
        vecs.push_back('{RR, 3'd7, FM, 32'd100,      32'd7,        32'd2,        1'b0,1'b0,1'b0,1'b0,33});
        vecs.push_back('{RR, 3'd0, FM, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 1'b0,1'b1,1'b0,1'b0,33});
        vecs.push_back('{RR, 3'd3, FM, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0,1'b0,1'b0,1'b0,33});
        vecs.push_back('{RR, 3'd2, FM, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,1'b0,1'b0,1'b0,33});
        vecs.push_back('{RR, 3'd4, FM, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0,1'b1,1'b0,1'b0,33});
        vecs.push_back('{RR, 3'd6, FM, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0,1'b1,1'b0,1'b0,33});
        vecs.push_back('{RR, 3'd4, FM, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0,1'b1,1'b1,1'b0,1});
        vecs.push_back('{RR, 3'd6, FM, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1,1'b1,1'b1,1'b0,1});
        vecs.push_back('{RR, 3'd4, FM, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0,1'b0,1'b1,1'b0,33});
        vecs.push_back('{RR, 3'd6, FM, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0,1'b0,1'b1,1'b0,33});

        // Reset state while rst is held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result",    result,         32'd0);
        chk("rst_zero",      32'(zero),      32'd0);
        chk("rst_lt",        32'(lt),        32'd0);
        chk("rst_ltu",       32'(ltu),       32'd0);
        chk("rst_illegal",   32'(illegal),   32'd0);
        rst = 1'b0;

        // Table of single ops, each drained immediately.
        for (int i = 0; i < vecs.size(); i++) begin
            nm = $sformatf("v%0d", i);
            start_op(vecs[i].aluop, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b);
            wait_result(lat);
            chk({nm, "_lat"},     32'(lat),      32'(vecs[i].lat));
            chk({nm, "_result"},  result,        vecs[i].res);
            chk({nm, "_zero"},    32'(zero),     32'(vecs[i].zero));
            chk({nm, "_lt"},      32'(lt),       32'(vecs[i].lt));
            chk({nm, "_ltu"},     32'(ltu),      32'(vecs[i].ltu));
            chk({nm, "_illegal"}, 32'(illegal),  32'(vecs[i].ill));
            if (lat != 999) drain(nm);
        end

        // DIVU 100/7 held by back-pressure for 5 cycles; new offers are ignored meanwhile.
        start_op(RR, 3'd5, FM, 32'd100, 32'd7);
        wait_result(lat);
        chk("hold_lat", 32'(lat), 32'd33);
        for (int k = 0; k < 5; k++) begin
            chk("hold_result",   result,          32'd14);
            chk("hold_ovalid",   32'(out_valid),  32'd1);
            chk("hold_in_ready", 32'(in_ready),   32'd0);
            aluop = RR; funct3 = 3'd0; funct7 = FB; opa = 32'd1; opb = 32'd1;
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("hold_last_result", result, 32'd14);
        chk("hold_m_in_ready",  32'(in_ready), 32'd0);
        drain("hold");
        repeat (2) @(negedge clk);
        chk("hold_no_extra", 32'(out_valid), 32'd0);

        // Reset during a DIV at cycle N+10: result discarded, never presented.
        start_op(RR, 3'd4, FM, 32'd100, 32'd7);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ovalid",   32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready),  32'd0);
        chk("midrst_result",   result,         32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_idle", 32'(in_ready), 32'd1);
        ov_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        chk("midrst_never_valid", 32'(ov_seen), 32'd0);

        // A fresh ADD after reset completes normally.
        start_op(RR, 3'd0, FB, 32'd3, 32'd4);
        wait_result(lat);
        chk("post_rst_lat",    32'(lat), 32'd1);
        chk("post_rst_result", result,   32'd7);
        chk("post_rst_zero",   32'(zero), 32'd0);
        if (lat != 999) drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "simulation timeout");
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised successor to the single-cycle ALU control decoder. It combines full RV32I/M operation decode with a registered ALU datapath and an iterative multiply/divide engine behind a valid/ready handshake. The block sits in the execute stage. It receives aluop/funct3/funct7 from the main control unit and operands from the register file/immediate mux. It returns a result plus branch flags, and stalls the core while a multi-cycle operation runs.

## Interface
- XLEN, 32, operand/result width (≥8, power of two)
- ENABLE_M, 1, 1 = decode funct7=0000001 as M-extension ops; 0 = flag them illegal
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept (high only in IDLE and rst low)
- aluop  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type
- funct3  in  3  instruction funct3
- funct7  in  7  instruction funct7 (full field, not 1 bit)
- opa, opb  in  XLEN  operands (opb = immediate for I-type)
- out_valid  out  1  result valid, held until out_ready
- out_ready  in  1  consumer accepts result
- result  out  XLEN  operation result
- zero, lt, ltu  out  1 each  result==0; signed opa<opb; unsigned opa<opb
- illegal  out  1  undecodable aluop/funct combination

## Operation
- Decode on in_valid && in_ready:
  - aluop 00 → ADD.
  - aluop 01 → SUB; flags carry the compare.
  - aluop 10, funct7 0000000 → ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by funct3.
  - aluop 10, funct7 0100000 → SUB (f3 000) or SRA (f3 101); other f3 illegal.
  - aluop 10, funct7 0000001 with ENABLE_M → MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (f3 000..111).
  - aluop 11 → same as R-type funct7=0, funct7 ignored except shifts. f3 001 requires funct7 0000000. f3 101 with funct7 0000000 → SRLI, 0100000 → SRAI, else illegal.
- Shift amount = opb[$clog2(XLEN)-1:0].
- Illegal: result 0, illegal=1, single-cycle latency.
- Multiply: shift-add over absolute values, 2·XLEN-bit product, sign fixed at end. MUL returns low half; MULH* return high half.
- Divide: restoring shift-subtract over magnitudes. Quotient sign = sign(a)^sign(b). Remainder sign = sign(a).
- Division special cases complete in single-cycle latency, engine not started:
  - divisor 0 → quotient all-ones, remainder = opa.
  - signed overflow (−2^(XLEN−1) / −1) → quotient −2^(XLEN−1), remainder 0.
- FSM states:
  - IDLE: accept; single-cycle ops → DONE, M ops → CALC.
  - CALC: counter XLEN−1..0; at 0 → DONE.
  - DONE: out_valid=1; out_ready → IDLE.
- zero/lt/ltu are registered with result for every operation. lt/ltu always compare the captured opa/opb.

## Timing
- Reset: state IDLE, out_valid 0, result 0, zero 0, lt 0, ltu 0, illegal 0, counter 0; in_ready 0 while rst high.
- Accept in cycle N. Single-cycle/illegal/special-case ops → out_valid in N+1. M ops → out_valid in N+XLEN+1.
- out_valid && !out_ready: result and flags held stable, in_ready 0.
- Handshake completes in cycle M (out_valid && out_ready). in_ready rises in M+1. No accept in the same cycle as result drain; throughput is one op per 2 cycles minimum.
- in_valid ignored whenever in_ready=0. Operands are captured at accept; later changes have no effect.
- rst in any state (including mid-CALC) → IDLE next cycle; in-flight result discarded, no out_valid.

## Structure
- Package alu_pkg:
  - aluop encodings (ALUOP_MEM/BR/R/I)
  - funct7 constants (F7_BASE, F7_ALT, F7_MULDIV)
  - alu_op_e enum (ADD..AND, MUL..REMU, ILLEGAL)
  - fsm state enum
- Sub-module alu_muldiv_iter: iterative engine with start/busy/done, opcode, operands, XLEN parameter. Top holds decode, single-cycle datapath, FSM, and output registers.

## Test plan
- aluop=10, f7=0000000, f3=000, opa=5, opb=7 → N+1: result=12, zero=0, illegal=0.
- aluop=01, f3=000, opa=opb=0x1234 → result=0, zero=1; opa=−1, opb=1 → lt=1, ltu=0.
- aluop=11, f3=101, f7=0100000, opa=0x80000000, opb=4 → result=0xF8000000; f7=0000011 → illegal=1, result=0.
- MULH opa=0x80000000, opb=2 → out_valid exactly N+33, result=0xFFFFFFFF. DIV by 0 (opa=9) → N+1, result=0xFFFFFFFF. REM same operands → result=9.
- DIVU 100/7 with out_ready low 5 cycles after out_valid → result=14 held stable, in_ready=0 throughout. REMU → 2.
- Assert rst at cycle N+10 of a DIV → next cycle IDLE, out_valid never asserted. A new ADD after reset completes normally.
